// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the memory access sequencer.
// Contents: access type codes (BYTE/HALF/WORD), RW encoding, sequencer
// state type and the access-size helper.
package cpu_mem_pkg;

  // Access size codes carried on req_type / mem_type
  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10,
    ACC_RSVD = 2'b11
  } acc_type_e;

  // Direction encoding shared by req_rw and mem_rw
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ACK   = 3'd2,
    ST_REL   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // Number of bytes touched by an access; reserved codes count as one byte
  function automatic logic [2:0] size_bytes(input logic [1:0] acc_type);
    case (acc_type)
      ACC_HALF: size_bytes = 3'd2;
      ACC_WORD: size_bytes = 3'd4;
      default:  size_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the request/response signals of the control unit and the
// MOV/MOC signals of the byte-wide RAM, as seen by the access sequencer.
// Modports:
//   slave  - the sequencer (takes requests, drives the RAM side)
//   master - control unit plus RAM (issues requests, answers MOV with MOC)
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_rw;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_mov;
  logic              mem_rw;
  logic [1:0]        mem_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_moc;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_rw, req_type, req_addr, req_wdata, mem_moc, mem_rdata,
    output busy, done, err, rdata, mem_mov, mem_rw, mem_type, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_rw, req_type, req_addr, req_wdata, mem_moc, mem_rdata,
    input  busy, done, err, rdata, mem_mov, mem_rw, mem_type, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_align_check.sv
// Combinational legality check of an access request.
// Ports:
//   acc_type in  2       access size code
//   addr     in  ADDR_W  byte address
//   bad_c    out 1       reserved type, misaligned, or access runs past the top of memory
module mem_align_check
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [1:0]        acc_type,
  input  logic [ADDR_W-1:0] addr,
  output logic              bad_c
);

  logic [ADDR_W:0] last_c;
  logic            misalign_c;

  // One extra bit on the last-byte address catches wrap past the top
  always_comb begin
    last_c = {1'b0, addr} + (ADDR_W + 1)'(size_bytes(acc_type)) - (ADDR_W + 1)'(1);
    case (acc_type)
      ACC_BYTE: misalign_c = 1'b0;
      ACC_HALF: misalign_c = addr[0];
      ACC_WORD: misalign_c = |addr[1:0];
      default:  misalign_c = 1'b1;
    endcase
    bad_c = misalign_c | last_c[ADDR_W];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between control unit and byte-wide RAM. Takes one request at a
// time, runs the four-phase MOV/MOC handshake, latches size-masked read
// data and reports done/err.
// Ports:
//   CLK  in  clock, rising edge
//   CLR  in  asynchronous reset, active-high
//   bus  mem_access_ctrl_if.slave: req_* in, busy/done/err/rdata out,
//        mem_mov/rw/type/addr/wdata out, mem_moc/mem_rdata in
// Optional feature: MEM_TIMEOUT_EN adds a TIMEOUT-cycle MOC watchdog in ACK.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input logic              CLK,
  input logic              CLR,
  mem_access_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              accept_c, load_rdata_c, bad_c, tmo_hit_c;
  logic              rw_q;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rmask_c;
  logic              busy_q, done_q, err_q, mov_q;

  mem_align_check #(.ADDR_W(ADDR_W)) u_align (
    .acc_type (bus.req_type),
    .addr     (bus.req_addr),
    .bad_c    (bad_c)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // Counts cycles spent in ACK; cleared everywhere else
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)                    tmo_q <= '0;
    else if (state_q == ST_ACK) tmo_q <= tmo_q + TMO_W'(1);
    else                        tmo_q <= '0;
  end

  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    load_rdata_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_c = 1'b1;
          state_d  = bad_c ? ST_ERROR : ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACK;
      ST_ACK: begin
        if (bus.mem_moc) begin
          load_rdata_c = (rw_q == RW_READ);
          state_d      = ST_REL;
        end else if (tmo_hit_c) begin
          state_d = ST_ERROR;
        end
      end
      ST_REL:   if (!bus.mem_moc) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and Moore outputs registered from the next state
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE) || (state_d == ST_ERROR);
      err_q   <= (state_d == ST_ERROR);
      mov_q   <= (state_d == ST_ACK);
    end
  end

  // Read data masked to the access size, zero-extended
  always_comb begin
    case (type_q)
      ACC_BYTE: rmask_c = DATA_W'(bus.mem_rdata[7:0]);
      ACC_HALF: rmask_c = DATA_W'(bus.mem_rdata[15:0]);
      default:  rmask_c = bus.mem_rdata;
    endcase
  end

  // Request capture (held stable through the handshake) and read-data latch
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rw_q    <= 1'b0;
      type_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        rw_q    <= bus.req_rw;
        type_q  <= bus.req_type;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (load_rdata_c) rdata_q <= rmask_c;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_mov   = mov_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_type  = type_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
